proto245a_responder: RTL and testbench

- Synthesizable FT245-style asynchronous FIFO responder: the chip side of the FT245 async protocol.
- Drives RXF#/TXE# and read data, and samples RD#/WR# and write data from a proto245a master.
- Exposes host-side valid/ready streams: host->buffer->master and master->buffer->host.
- Used for FPGA loopback, self-test and co-simulation against the master without an FTDI device.

---
 rtl/proto245a_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_proto245a_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proto245a_responder.sv
// rtl/proto245a_responder.sv - FT245-style async FIFO responder (chip side of the proto245a link)
// Optional protocol checker enabled by defining PROTO245A_RESPONDER_CHECK_EN.
module proto245a_responder #(
    parameter int DATA_W             = 8,
    parameter int RXBUF_SIZE         = 16,
    parameter int TXBUF_SIZE         = 16,
    parameter int RXF_INACTIVE_TICKS = 4,
    parameter int TXE_INACTIVE_TICKS = 4
) (
    input  logic                        ft_clk,
    input  logic                        ft_rst_n,
    output logic                        ft_rxfn,
    output logic                        ft_txen,
    input  logic                        ft_rdn,
    input  logic                        ft_wrn,
    input  logic [DATA_W-1:0]           ft_din,
    output logic [DATA_W-1:0]           ft_dout,
    input  logic                        ft_siwu,
    input  logic [DATA_W-1:0]           host_wdata,
    input  logic                        host_wvalid,
    output logic                        host_wready,
    output logic [DATA_W-1:0]           host_rdata,
    output logic                        host_rvalid,
    input  logic                        host_rready,
    output logic [$clog2(RXBUF_SIZE):0] rxbuf_load,
    output logic [$clog2(TXBUF_SIZE):0] txbuf_load,
    output logic [2:0]                  proto_err
);
    localparam int RX_AW     = $clog2(RXBUF_SIZE);
    localparam int TX_AW     = $clog2(TXBUF_SIZE);
    localparam int MAX_TICKS = (RXF_INACTIVE_TICKS > TXE_INACTIVE_TICKS) ?
                               RXF_INACTIVE_TICKS : TXE_INACTIVE_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] RX_RECOV = CNT_W'(RXF_INACTIVE_TICKS - 1);
    localparam logic [CNT_W-1:0] TX_RECOV = CNT_W'(TXE_INACTIVE_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE_S,
        RD_S,
        RD_RECOV_S,
        WR_S,
        WR_RECOV_S
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ft_rxfn_q, ft_rxfn_d;
    logic                ft_txen_q, ft_txen_d;
    logic [DATA_W-1:0]   ft_dout_q, ft_dout_d;
    logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;

    logic                rdn_meta_q, rdn_s_q;
    logic                wrn_meta_q, wrn_s_q;
    logic [DATA_W-1:0]   din_meta_q, din_s_q;

    logic [DATA_W-1:0]   rx_mem [RXBUF_SIZE];
    logic [DATA_W-1:0]   tx_mem [TXBUF_SIZE];
    logic [RX_AW:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TX_AW:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;

    logic                rx_empty, rx_full, tx_empty, tx_full;
    logic                rx_push, rx_pop, tx_push, tx_pop;
    logic [DATA_W-1:0]   rx_head;
    logic                siwu_unused;

    assign siwu_unused = ft_siwu;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full  = (rx_wr_ptr_q[RX_AW] != rx_rd_ptr_q[RX_AW]) &&
                      (rx_wr_ptr_q[RX_AW-1:0] == rx_rd_ptr_q[RX_AW-1:0]);
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full  = (tx_wr_ptr_q[TX_AW] != tx_rd_ptr_q[TX_AW]) &&
                      (tx_wr_ptr_q[TX_AW-1:0] == tx_rd_ptr_q[TX_AW-1:0]);

    assign rx_head  = rx_mem[rx_rd_ptr_q[RX_AW-1:0]];
    assign rx_push  = host_wvalid && !rx_full;
    assign tx_pop   = host_rready && !tx_empty;

    assign host_wready = !rx_full;
    assign host_rvalid = !tx_empty;
    assign host_rdata  = tx_mem[tx_rd_ptr_q[TX_AW-1:0]];
    assign rxbuf_load  = rx_wr_ptr_q - rx_rd_ptr_q;
    assign txbuf_load  = tx_wr_ptr_q - tx_rd_ptr_q;
    assign ft_rxfn     = ft_rxfn_q;
    assign ft_txen     = ft_txen_q;
    assign ft_dout     = ft_dout_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_hold_d = tx_hold_q;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (!ft_rxfn_q && !rdn_s_q) begin
                    state_d = RD_S;
                end else if (!ft_txen_q && !wrn_s_q && rdn_s_q) begin
                    state_d   = WR_S;
                    tx_hold_d = din_s_q;
                end
            end
            RD_S: begin
                if (rdn_s_q) begin
                    rx_pop  = 1'b1;
                    cnt_d   = RX_RECOV;
                    state_d = RD_RECOV_S;
                end
            end
            WR_S: begin
                if (!wrn_s_q) begin
                    tx_hold_d = din_s_q;
                end else begin
                    tx_push = 1'b1;
                    cnt_d   = TX_RECOV;
                    state_d = WR_RECOV_S;
                end
            end
            RD_RECOV_S, WR_RECOV_S: begin
                if (cnt_q == '0) begin
                    state_d = IDLE_S;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE_S;
        endcase

        // Strobes and read data follow the next state so RXF# never drops with stale data.
        ft_rxfn_d = !(((state_d == IDLE_S) && !rx_empty) || (state_d == RD_S));
        ft_txen_d = !(((state_d == IDLE_S) && !tx_full) || (state_d == WR_S));
        ft_dout_d = ((state_d == IDLE_S) && !rx_empty) ? rx_head : ft_dout_q;

        rx_wr_ptr_d = rx_wr_ptr_q + (RX_AW+1)'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + (RX_AW+1)'(rx_pop);
        tx_wr_ptr_d = tx_wr_ptr_q + (TX_AW+1)'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + (TX_AW+1)'(tx_pop);
    end

    always_ff @(posedge ft_clk or negedge ft_rst_n) begin
        if (!ft_rst_n) begin
            state_q     <= IDLE_S;
            cnt_q       <= '0;
            ft_rxfn_q   <= 1'b1;
            ft_txen_q   <= 1'b1;
            ft_dout_q   <= '0;
            tx_hold_q   <= '0;
            rdn_meta_q  <= 1'b1;
            rdn_s_q     <= 1'b1;
            wrn_meta_q  <= 1'b1;
            wrn_s_q     <= 1'b1;
            din_meta_q  <= '0;
            din_s_q     <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ft_rxfn_q   <= ft_rxfn_d;
            ft_txen_q   <= ft_txen_d;
            ft_dout_q   <= ft_dout_d;
            tx_hold_q   <= tx_hold_d;
            rdn_meta_q  <= ft_rdn;
            rdn_s_q     <= rdn_meta_q;
            wrn_meta_q  <= ft_wrn;
            wrn_s_q     <= wrn_meta_q;
            din_meta_q  <= ft_din;
            din_s_q     <= din_meta_q;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
        end
    end

    always_ff @(posedge ft_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q[RX_AW-1:0]] <= host_wdata;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q[TX_AW-1:0]] <= tx_hold_q;
        end
    end

`ifdef PROTO245A_RESPONDER_CHECK_EN
    logic       rdn_p_q, wrn_p_q;
    logic [2:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (rdn_p_q && !rdn_s_q && ft_rxfn_q && (state_q != RD_S)) begin
            err_d[0] = 1'b1;
        end
        if (wrn_p_q && !wrn_s_q && ft_txen_q && (state_q != WR_S)) begin
            err_d[1] = 1'b1;
        end
        if (!rdn_s_q && !wrn_s_q) begin
            err_d[2] = 1'b1;
        end
    end

    always_ff @(posedge ft_clk or negedge ft_rst_n) begin
        if (!ft_rst_n) begin
            rdn_p_q <= 1'b1;
            wrn_p_q <= 1'b1;
            err_q   <= '0;
        end else begin
            rdn_p_q <= rdn_s_q;
            wrn_p_q <= wrn_s_q;
            err_q   <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 3'b000;
`endif

endmodule

// File: tb/tb_proto245a_responder.sv
// tb/tb_proto245a_responder.sv - self-checking bench for proto245a_responder (queue model + directed vectors)
module tb_proto245a_responder;
    localparam int BUFN = 16;
`ifdef PROTO245A_RESPONDER_CHECK_EN
    localparam logic [2:0] EXP_CONF = 3'b100;
    localparam logic [2:0] EXP_VIOL = 3'b101;
`else
    localparam logic [2:0] EXP_CONF = 3'b000;
    localparam logic [2:0] EXP_VIOL = 3'b000;
`endif

    logic       clk, rst_n;
    logic       ft_rxfn, ft_txen, ft_rdn, ft_wrn, ft_siwu;
    logic [7:0] ft_din, ft_dout;
    logic [7:0] host_wdata, host_rdata;
    logic       host_wvalid, host_wready, host_rvalid, host_rready;
    logic [4:0] rxbuf_load, txbuf_load;
    logic [2:0] proto_err;

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model: buffer contents as queues, strobe-release events scheduled by the driver.
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         cyc = 0;
    int         rx_pop_at = -1;
    int         tx_push_at = -1;
    logic [7:0] tx_push_val = 8'h00;

    proto245a_responder dut (
        .ft_clk      (clk),
        .ft_rst_n    (rst_n),
        .ft_rxfn     (ft_rxfn),
        .ft_txen     (ft_txen),
        .ft_rdn      (ft_rdn),
        .ft_wrn      (ft_wrn),
        .ft_din      (ft_din),
        .ft_dout     (ft_dout),
        .ft_siwu     (ft_siwu),
        .host_wdata  (host_wdata),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_rready (host_rready),
        .rxbuf_load  (rxbuf_load),
        .txbuf_load  (txbuf_load),
        .proto_err   (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
        end else begin
            automatic bit rx_acc = host_wvalid && (rx_q.size() < BUFN);
            automatic bit tx_pop = host_rready && (tx_q.size() > 0);
            cyc++;
            if (cyc == rx_pop_at && rx_q.size() > 0) rx_q.delete(0);
            if (rx_acc) rx_q.push_back(host_wdata);
            if (tx_pop) tx_q.delete(0);
            if (cyc == tx_push_at) tx_q.push_back(tx_push_val);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rxbuf_load", 32'(rxbuf_load), 32'(rx_q.size()));
            chk("txbuf_load", 32'(txbuf_load), 32'(tx_q.size()));
            chk("host_wready", 32'(host_wready), 32'(rx_q.size() < BUFN));
            chk("host_rvalid", 32'(host_rvalid), 32'(tx_q.size() > 0));
            if (tx_q.size() > 0) chk("host_rdata", 32'(host_rdata), 32'(tx_q[0]));
            if (ft_rxfn === 1'b0) begin
                chk("rxfn_low_needs_data", 32'(rx_q.size() > 0), 32'd1);
                if (rx_q.size() > 0) chk("ft_dout", 32'(ft_dout), 32'(rx_q[0]));
            end
            if (ft_txen === 1'b0) chk("txen_low_needs_space", 32'(tx_q.size() < BUFN), 32'd1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched so far", n_cmp, n_fail);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [7:0] d);
        host_wdata  = d;
        host_wvalid = 1'b1;
        tick();
        host_wvalid = 1'b0;
    endtask

    task automatic host_pop();
        host_rready = 1'b1;
        tick();
        host_rready = 1'b0;
    endtask

    task automatic wait_rx_low(input int bound, output int n);
        n = 0;
        while (ft_rxfn !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_tx_low(input int bound, output int n);
        n = 0;
        while (ft_txen !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Returns just after the edge that pops the word (RD# release + two sync stages + FSM edge).
    task automatic master_read(input int hold, output logic [7:0] d);
        int n;
        wait_rx_low(64, n);
        chk("rd_rxfn_wait", 32'(n < 64), 32'd1);
        ft_rdn = 1'b0;
        repeat (hold) tick();
        d = ft_dout;
        ft_rdn = 1'b1;
        rx_pop_at = cyc + 3;
        repeat (3) tick();
    endtask

    task automatic master_write(input logic [7:0] d);
        int n;
        wait_tx_low(64, n);
        chk("wr_txen_wait", 32'(n < 64), 32'd1);
        ft_din = d;
        ft_wrn = 1'b0;
        repeat (4) tick();
        ft_wrn = 1'b1;
        tx_push_val = d;
        tx_push_at = cyc + 3;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] d;
        int n;
        rst_n = 1'b0;
        ft_rdn = 1'b1;
        ft_wrn = 1'b1;
        ft_din = 8'h00;
        ft_siwu = 1'b1;
        host_wdata = 8'h00;
        host_wvalid = 1'b0;
        host_rready = 1'b0;
        repeat (3) tick();
        chk("rst_rxfn", 32'(ft_rxfn), 32'd1);
        chk("rst_txen", 32'(ft_txen), 32'd1);
        chk("rst_dout", 32'(ft_dout), 32'd0);
        chk("rst_rxload", 32'(rxbuf_load), 32'd0);
        chk("rst_txload", 32'(txbuf_load), 32'd0);
        chk("rst_wready", 32'(host_wready), 32'd1);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_rxfn_empty", 32'(ft_rxfn), 32'd1);
        chk("idle_txen_space", 32'(ft_txen), 32'd0);

        host_push(8'hA5);
        chk("a5_rxfn_after_1", 32'(ft_rxfn), 32'd1);
        tick();
        chk("a5_rxfn_after_2", 32'(ft_rxfn), 32'd0);
        chk("a5_dout", 32'(ft_dout), 32'hA5);
        chk("a5_load_before", 32'(rxbuf_load), 32'd1);
        master_read(4, d);
        chk("a5_read", 32'(d), 32'hA5);
        chk("a5_load_after", 32'(rxbuf_load), 32'd0);
        wait_rx_low(12, n);
        chk("a5_rxfn_stays_high", 32'(n), 32'd12);

        host_push(8'h11);
        host_push(8'h22);
        master_read(4, d);
        chk("rd_first", 32'(d), 32'h11);
        wait_rx_low(20, n);
        chk("rxf_recovery_len", 32'(n), 32'd4);
        master_read(4, d);
        chk("rd_second", 32'(d), 32'h22);

        master_write(8'h3C);
        chk("3c_txload", 32'(txbuf_load), 32'd1);
        chk("3c_rdata", 32'(host_rdata), 32'h3C);
        chk("3c_rvalid", 32'(host_rvalid), 32'd1);
        chk("3c_txen_high", 32'(ft_txen), 32'd1);
        wait_tx_low(20, n);
        chk("txe_recovery_len", 32'(n), 32'd4);
        host_pop();
        chk("3c_popped", 32'(txbuf_load), 32'd0);

        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) host_push(8'(b * 16 + i));
            chk("fill_wready", 32'(host_wready), 32'd0);
            chk("fill_load", 32'(rxbuf_load), 32'd16);
            host_push(8'hEE);
            chk("fill_refused", 32'(rxbuf_load), 32'd16);
            for (int i = 0; i < 16; i++) begin
                master_read(4, d);
                chk("fill_order", 32'(d), 32'(b * 16 + i));
            end
            chk("fill_drained", 32'(rxbuf_load), 32'd0);
        end

        for (int i = 0; i < 16; i++) master_write(8'(8'h40 + i));
        chk("txfull_load", 32'(txbuf_load), 32'd16);
        wait_tx_low(20, n);
        chk("txfull_txen_held", 32'(n), 32'd20);
        chk("txfull_head", 32'(host_rdata), 32'h40);
        host_pop();
        wait_tx_low(20, n);
        chk("txfull_reenable", 32'(n >= 1 && n <= 2), 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk("txfull_order", 32'(host_rdata), 32'(8'h40 + i));
            host_pop();
        end
        chk("txfull_drained", 32'(host_rvalid), 32'd0);

        host_push(8'h77);
        wait_rx_low(20, n);
        chk("conf_txen_ready", 32'(ft_txen), 32'd0);
        ft_din = 8'hEE;
        ft_rdn = 1'b0;
        ft_wrn = 1'b0;
        repeat (4) tick();
        d = ft_dout;
        ft_rdn = 1'b1;
        ft_wrn = 1'b1;
        rx_pop_at = cyc + 3;
        repeat (3) tick();
        chk("conf_read", 32'(d), 32'h77);
        chk("conf_rxload", 32'(rxbuf_load), 32'd0);
        repeat (10) tick();
        chk("conf_no_push", 32'(txbuf_load), 32'd0);
        chk("conf_err", 32'(proto_err), 32'(EXP_CONF));

        ft_rdn = 1'b0;
        repeat (4) tick();
        ft_rdn = 1'b1;
        repeat (6) tick();
        chk("viol_no_pop", 32'(rxbuf_load), 32'd0);
        chk("viol_err", 32'(proto_err), 32'(EXP_VIOL));

        host_push(8'h99);
        wait_rx_low(20, n);
        ft_rdn = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rxfn", 32'(ft_rxfn), 32'd1);
        chk("mid_rst_txen", 32'(ft_txen), 32'd1);
        chk("mid_rst_dout", 32'(ft_dout), 32'd0);
        chk("mid_rst_rxload", 32'(rxbuf_load), 32'd0);
        chk("mid_rst_txload", 32'(txbuf_load), 32'd0);
        chk("mid_rst_err", 32'(proto_err), 32'd0);
        ft_rdn = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        host_push(8'h5A);
        master_read(4, d);
        chk("post_rst_read", 32'(d), 32'h5A);
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
